// File: rtl/johnson4_decoder.sv
// Johnson-code receiver: decodes a 4-bit twisted-ring word to a phase index and tracks sequence lock.
// Optional JOHNSON4_DEC_HOLD_EN: a repeated phase in TRACK/LOCKED is accepted instead of raising seq_err.
module johnson4_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       q_in,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t           state, state_n;
    logic [7:0]       run, run_n;
    logic [8:0]       run_inc;
    logic [2:0]       phase_n, phase_succ, code_phase;
    logic             code_ok, is_succ, is_hold;
    logic             pv_n, ill_n, se_n, locked_n;
    logic [ERR_W-1:0] err_n;

    // q_in[3] is stage0, so the ring fills from the MSB side.
    always_comb begin
        code_ok    = 1'b1;
        code_phase = 3'd0;
        case (q_in)
            4'b0000: code_phase = 3'd0;
            4'b1000: code_phase = 3'd1;
            4'b1100: code_phase = 3'd2;
            4'b1110: code_phase = 3'd3;
            4'b1111: code_phase = 3'd4;
            4'b0111: code_phase = 3'd5;
            4'b0011: code_phase = 3'd6;
            4'b0001: code_phase = 3'd7;
            default: code_ok = 1'b0;
        endcase
    end

    assign phase_succ = phase + 3'd1;
    assign is_succ    = (code_phase == phase_succ);
    assign run_inc    = {1'b0, run} + 9'd1;

`ifdef JOHNSON4_DEC_HOLD_EN
    assign is_hold = (code_phase == phase);
`else
    assign is_hold = 1'b0;
`endif

    always_comb begin
        state_n = state;
        run_n   = run;
        phase_n = phase;
        pv_n    = 1'b0;
        ill_n   = 1'b0;
        se_n    = 1'b0;
        if (in_valid) begin
            if (!code_ok) begin
                ill_n   = 1'b1;
                state_n = SEARCH;
                run_n   = 8'd0;
            end else begin
                pv_n = 1'b1;
                case (state)
                    SEARCH: begin
                        phase_n = code_phase;
                        run_n   = 8'd0;
                        state_n = TRACK;
                    end
                    TRACK, LOCKED: begin
                        if (is_succ) begin
                            phase_n = code_phase;
                            if (state == TRACK) begin
                                run_n = run_inc[7:0];
                                if (run_inc == 9'(LOCK_COUNT))
                                    state_n = LOCKED;
                            end
                        end else if (!is_hold) begin
                            se_n    = 1'b1;
                            phase_n = code_phase;
                            run_n   = 8'd0;
                            state_n = TRACK;
                        end
                    end
                    default: state_n = SEARCH;
                endcase
            end
        end
        locked_n = (state_n == LOCKED);
        err_n    = err_count;
        if ((ill_n || se_n) && (err_count != '1))
            err_n = err_count + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            run         <= 8'd0;
            phase       <= 3'd0;
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            run         <= run_n;
            phase       <= phase_n;
            phase_valid <= pv_n;
            illegal     <= ill_n;
            seq_err     <= se_n;
            locked      <= locked_n;
            err_count   <= err_n;
        end
    end

endmodule
